store_retire_buffer: RTL



---
 rtl/store_retire_buffer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/store_retire_buffer.sv
// store_retire_buffer
// Post-retirement store buffer on the ROB retire port. Up to three retired
// stores per cycle are compacted into a circular FIFO (slot 2 oldest) and
// drained one at a time, in program order, to the D-cache over a req/ack
// handshake. Entries are architecturally committed, so nothing here ever
// flushes them except reset. Free space is reported back to the ROB on
// sq_stall from the registered occupancy only.
module store_retire_buffer #(
  parameter int SQ_DEPTH = 8,
  parameter int XLEN     = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                ret_valid,
  input  logic [2:0]                ret_is_store,
  input  logic [3*XLEN-1:0]         ret_addr,
  input  logic [3*XLEN-1:0]         ret_data,
  input  logic [5:0]                ret_size,
  output logic [2:0]                sq_stall,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_data,
  output logic [1:0]                mem_size,
  input  logic                      mem_ack,
  output logic                      sq_empty,
  output logic [$clog2(SQ_DEPTH):0] sq_count,
  output logic                      overflow
);

  localparam int IW = $clog2(SQ_DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drainState_t;

  drainState_t r_state;
  drainState_t w_stateNext;

  logic [XLEN-1:0] r_addr [SQ_DEPTH];
  logic [XLEN-1:0] r_data [SQ_DEPTH];
  logic [1:0]      r_size [SQ_DEPTH];

  logic [IW-1:0]   r_head;
  logic [IW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  logic [2:0]      w_slotPush;
  logic [1:0]      w_pos [3];
  logic [1:0]      w_numPush;
  logic [CW-1:0]   w_free;
  logic            w_overflowNow;
  logic [CW-1:0]   w_numWrite;
  logic            w_wrEn [3];
  logic [IW-1:0]   w_wrIdx [3];
  logic            w_pop;
  logic [CW-1:0]   w_countNext;

  // Free space is taken from the registered count only; a drain in the
  // same cycle is deliberately not credited to the ROB.
  assign w_free = CW'(SQ_DEPTH) - r_count;

  // Compaction: each pushed slot lands at tail plus the number of older
  // pushed slots, so non-store slots leave no holes in the FIFO.
  always_comb begin
    w_slotPush = ret_valid & ret_is_store;
    w_pos[2]   = 2'd0;
    w_pos[1]   = {1'b0, w_slotPush[2]};
    w_pos[0]   = w_pos[1] + {1'b0, w_slotPush[1]};
    w_numPush  = w_pos[0] + {1'b0, w_slotPush[0]};
  end

  // Only the oldest 'free' pushed stores are written; anything beyond that
  // is dropped and flagged as a ROB protocol violation.
  always_comb begin
    w_overflowNow = (CW'(w_numPush) > w_free);
    w_numWrite    = w_overflowNow ? w_free : CW'(w_numPush);
    for (int i = 0; i < 3; i++) begin
      w_wrEn[i]  = w_slotPush[i] && (CW'(w_pos[i]) < w_free);
      w_wrIdx[i] = r_tail + IW'(w_pos[i]);
    end
  end

  // A pop happens only when a request is actually outstanding; an ack seen
  // while idle is ignored.
  always_comb begin
    w_pop       = (r_state == S_REQ) && mem_ack;
    w_countNext = r_count + w_numWrite - CW'(w_pop);
  end

  // Drain FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Drain FSM next state: a store pushed into an empty buffer is requested
  // on the very next cycle, and back-to-back drains stay in REQ.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_countNext != '0) begin
          w_stateNext = S_REQ;
        end
      end
      S_REQ: begin
        if (w_pop && (w_countNext == '0)) begin
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // FIFO storage, pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int j = 0; j < SQ_DEPTH; j++) begin
        r_addr[j] <= '0;
        r_data[j] <= '0;
        r_size[j] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_wrEn[i]) begin
          r_addr[w_wrIdx[i]] <= ret_addr[i*XLEN +: XLEN];
          r_data[w_wrIdx[i]] <= ret_data[i*XLEN +: XLEN];
          r_size[w_wrIdx[i]] <= ret_size[i*2 +: 2];
        end
      end
      r_tail     <= r_tail + w_numWrite[IW-1:0];
      r_head     <= r_head + IW'(w_pop);
      r_count    <= w_countNext;
      r_overflow <= r_overflow | w_overflowNow;
    end
  end

  // Drain FSM outputs: the head entry is presented only while requesting,
  // and it cannot change until the ack pops it.
  always_comb begin
    mem_req  = 1'b0;
    mem_addr = '0;
    mem_data = '0;
    mem_size = '0;
    case (r_state)
      S_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_addr[r_head];
        mem_data = r_data[r_head];
        mem_size = r_size[r_head];
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // Free-space code back to the ROB plus occupancy status.
  always_comb begin
    case (w_free)
      CW'(0):  sq_stall = 3'b111;
      CW'(1):  sq_stall = 3'b011;
      CW'(2):  sq_stall = 3'b001;
      default: sq_stall = 3'b000;
    endcase
    sq_count = r_count;
    sq_empty = (r_count == '0) && (r_state == S_IDLE);
    overflow = r_overflow;
  end

endmodule
